muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage of the 5-stage pipelined core.
- Takes a decoded M-extension op with forwarded operands, computes one bit per cycle and raises a stall request to hold IF/ID/EX until the result is ready.
- The result is muxed into ALUResultE by the integrating datapath when done is high.
- Generalised in XLEN; adds multi-cycle handshake, flush abort and RISC-V corner-case semantics.

Parameters:
XLEN, 32, operand/result width; any even value >= 8
CNT_W, $clog2(XLEN+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  EX holds a valid M-extension instruction
op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a  in  XLEN  rs1 operand (post-forwarding SrcAE)
b  in  XLEN  rs2 operand (post-forwarding WriteDataE)
flush  in  1  EX flush (FlushE); aborts the current op
stall_req  out  1  to hazard unit; holds StallF/StallD and suppresses the EX->MEM advance
busy  out  1  unit is in CALC or DONE
done  out  1  result valid, one-cycle pulse
result  out  XLEN  final result, held until the next start

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, stall_req=0, result=0, counter=0, internal registers cleared.
- States: IDLE, CALC, DONE.
- IDLE, start=1, flush=0:
  - Latch op, |a|, |b| and sign flags; stall_req=1 combinationally in this same cycle.
  - Next state is CALC, or DONE directly for a special case.
- CALC:
  - MUL*: shift-add, one multiplier bit per cycle into a 2*XLEN accumulator.
  - DIV*/REM*: restoring division, one quotient bit per cycle.
  - Counter runs 0..XLEN-1; after XLEN cycles go to DONE. stall_req=1 throughout.
- DONE:
  - done=1 and stall_req=0, so the pipeline advances this cycle; result is registered.
  - Next state is IDLE. start is ignored in DONE because it still belongs to the same instruction.
- Latency: start at cycle t gives done at t+XLEN+1 (t+33 for XLEN=32). Special cases give done at t+1.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Signed ops use magnitudes, then two's-complement negate at DONE.
  - Product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sign of dividend.
- Result select:
  - MUL returns product[XLEN-1:0].
  - MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
  - DIV* returns the quotient; REM* returns the remainder.
- Divide by zero (b=0), special case: DIV/DIVU give all ones; REM/REMU give a.
- Signed overflow (DIV/REM, a=100..0, b=all ones), special case: DIV gives a; REM gives 0.
- Flush:
  - In any state, flush=1 forces IDLE next cycle, done is not pulsed, and result is unchanged.
  - flush with start in IDLE means no op is accepted.
- Reset mid-operation: immediate IDLE, all outputs return to reset values.
- All arithmetic is modulo 2^XLEN or 2^(2*XLEN); there are no exceptions.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 op constants (OP_MUL..OP_REMU).
  - State encoding IDLE/CALC/DONE.
  - Helper predicates is_div(op), is_signed_a(op), is_signed_b(op).
- One natural sub-module, muldiv_negate: conditional two's-complement of a W-bit value, used for operand abs and result sign fix.
- The FSM and datapath stay in muldiv_unit.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> stall_req high 33 cycles; done at t+33; result=0xFFFFFFEB (-21).
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE. MULH same operands -> result=0x00000000. MULHSU a=-1, b=2 -> result=0xFFFFFFFF.
- DIV a=-7, b=2 -> result=0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). DIVU a=100, b=7 -> 14. REMU same operands -> 2.
- DIV a=5, b=0 -> done at t+1, result=0xFFFFFFFF. REM a=5, b=0 -> result=5. DIV a=0x80000000, b=-1 -> result=0x80000000 at t+1. REM same operands -> 0.
- Start DIVU, assert flush at cycle t+10 -> IDLE at t+11; no done pulse; stall_req=0 at t+11; result keeps its previous value. A new start at t+12 completes normally.
- Start MUL, drive rst=0 at t+5 between clock edges -> outputs go to 0 immediately (async). After release, start DIVU 9/3 -> result=3 at t'+33.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op encodings, FSM states and op-class predicates for
//               the iterative RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // funct3 encodings of the M extension
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Divide/remainder family lives in the upper half of funct3
  function automatic logic is_div(input logic [2:0] fn);
    return fn[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] fn);
    return (fn == OP_MUL) || (fn == OP_MULH) || (fn == OP_MULHSU) ||
           (fn == OP_DIV) || (fn == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] fn);
    return (fn == OP_MUL) || (fn == OP_MULH) ||
           (fn == OP_DIV) || (fn == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_negate.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_negate
// Description : Conditional two's-complement negation of a W-bit value.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = en_i ? (~val_i + W'(1)) : val_i;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit for the EX stage. One
//               multiplier/quotient bit per cycle, stall request while busy,
//               flush abort and RISC-V divide corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int               CNT_W    = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   hi_q, hi_d;      // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;      // multiplier bits / dividend-quotient
  logic [XLEN-1:0]   opnd_q, opnd_d;  // multiplicand / divisor magnitude
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              w_sa, w_sb;
  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic              w_div0, w_ovf;
  logic [XLEN-1:0]   w_special;
  logic [XLEN:0]     w_add, w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub, w_hi_step, w_lo_step;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_final;

  assign w_sa = is_signed_a(op) & a[XLEN-1];
  assign w_sb = is_signed_b(op) & b[XLEN-1];

  muldiv_negate #(.W(XLEN)) u_abs_a (.en_i(w_sa), .val_i(a), .val_o(w_abs_a));
  muldiv_negate #(.W(XLEN)) u_abs_b (.en_i(w_sb), .val_i(b), .val_o(w_abs_b));

  // Divide corner cases resolve in a single cycle from the raw operands
  always_comb begin
    w_div0    = is_div(op) && (b == '0);
    w_ovf     = is_div(op) && is_signed_a(op) && (a == MIN_NEG) && (b == '1);
    w_special = '0;
    if (w_div0) begin
      w_special = op[1] ? a : '1;
    end else if (w_ovf) begin
      w_special = op[1] ? '0 : a;
    end
  end

  // One shift-add or one restoring-subtract step on the shared registers
  always_comb begin
    w_add   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    w_shift = {hi_q, lo_q[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, opnd_q});
    w_sub   = w_shift[XLEN-1:0] - opnd_q;
    if (is_div(op_q)) begin
      w_hi_step = w_ge ? w_sub : w_shift[XLEN-1:0];
      w_lo_step = {lo_q[XLEN-2:0], w_ge};
    end else begin
      w_hi_step = w_add[XLEN:1];
      w_lo_step = {w_add[0], lo_q[XLEN-1:1]};
    end
  end

  muldiv_negate #(.W(2*XLEN)) u_neg_prod (
    .en_i (sa_q ^ sb_q),
    .val_i({w_hi_step, w_lo_step}),
    .val_o(w_prod)
  );
  muldiv_negate #(.W(XLEN)) u_neg_quo (.en_i(sa_q ^ sb_q), .val_i(w_lo_step), .val_o(w_quo));
  muldiv_negate #(.W(XLEN)) u_neg_rem (.en_i(sa_q),        .val_i(w_hi_step), .val_o(w_rem));

  // Pick the architectural result from the final step's values
  always_comb begin
    if (is_div(op_q)) begin
      w_final = op_q[1] ? w_rem : w_quo;
    end else if (op_q[1:0] == 2'b00) begin
      w_final = w_prod[XLEN-1:0];
    end else begin
      w_final = w_prod[2*XLEN-1:XLEN];
    end
  end

  // Next-state, datapath loads and handshake outputs
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    stall_req = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          // rst gate keeps the combinational request low while held in reset
          stall_req = rst;
          op_d      = op;
          sa_d      = w_sa;
          sb_d      = w_sb;
          cnt_d     = '0;
          hi_d      = '0;
          lo_d      = is_div(op) ? w_abs_a : w_abs_b;
          opnd_d    = is_div(op) ? w_abs_b : w_abs_a;
          if (w_div0 || w_ovf) begin
            result_d = w_special;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        stall_req = 1'b1;
        busy      = 1'b1;
        hi_d      = w_hi_step;
        lo_d      = w_lo_step;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          result_d = w_final;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = !flush;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // An EX flush abandons the instruction without touching the result
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: arithmetic reference
//               model, per-cycle handshake/result compare, directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        stall_req, busy, done;
  logic [31:0] result;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // model state for the operation in flight
  logic        chk_en  = 1'b0;
  logic        act     = 1'b0;
  int          t_start = 0;
  int          lat     = 0;
  int          t_abort = 0;
  logic [31:0] exp_val = 32'd0;
  logic [31:0] old_val = 32'd0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall_req(stall_req), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  // RISC-V M semantics with plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy, q;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    p  = 64'd0;
    q  = 0;
    case (f)
      3'd0: begin p = 64'(sx * sy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = 64'(ux * uy); return p[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        q = sx / sy; p = 64'(q); return p[31:0];
      end
      3'd5: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 32'd0) return x;
        q = sx % sy; p = 64'(q); return p[31:0];
      end
      default: begin
        if (y == 32'd0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && y == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Per-cycle compare of all outputs against the model's timeline
  always @(negedge clk) begin
    if (chk_en) begin
      int   rel;
      logic live;
      rel  = cyc - t_start;
      live = act && (cyc <= t_abort);
      check("stall_req", {31'd0, stall_req}, {31'd0, live && rel >= 0 && rel < lat});
      check("busy",      {31'd0, busy},      {31'd0, live && rel >= 1 && rel <= lat});
      check("done",      {31'd0, done},      {31'd0, live && rel == lat});
      check("result",    result, (live && rel >= lat) ? exp_val : old_val);
    end
  end

  task automatic launch(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    t_start = cyc;
    lat     = model_lat(f, x, y);
    exp_val = model(f, x, y);
    t_abort = 32'h3FFF_FFFF;
    act     = 1'b1;
    start   = 1'b1;
    op      = f;
    a       = x;
    b       = y;
    @(posedge clk); #1;
    start   = 1'b0;
    a       = $urandom;
    b       = $urandom;
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic has_lit, input logic [31:0] lit);
    launch(f, x, y);
    repeat (lat - 1) @(posedge clk);
    #1;
    if (has_lit) check(name, result, lit);
    @(posedge clk); #1;
    old_val = exp_val;
    act     = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic        has_lit;
    logic [31:0] lit;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,         1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFD});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{3'd5, 32'd100,        32'd7,         1'b1, 32'd14});
    vecs.push_back('{3'd7, 32'd100,        32'd7,         1'b1, 32'd2});
    vecs.push_back('{3'd4, 32'd5,          32'd0,         1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{3'd6, 32'd5,          32'd0,         1'b1, 32'd5});
    vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000});
    vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'd0});
    vecs.push_back('{3'd5, 32'd9,          32'd0,         1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{3'd7, 32'd9,          32'd0,         1'b1, 32'd9});
    vecs.push_back('{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'd0});
    vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 1'b1, 32'h4000_0000});
    vecs.push_back('{3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 32'd0});
    vecs.push_back('{3'd0, 32'h1234_5678,  32'h9ABC_DEF0, 1'b0, 32'd0});
    vecs.push_back('{3'd4, 32'h7FFF_FFFF,  32'hFFFF_FFFE, 1'b0, 32'd0});
    vecs.push_back('{3'd6, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFFE});
    vecs.push_back('{3'd5, 32'hFFFF_FFFF,  32'h0001_0000, 1'b1, 32'h0000_FFFF});

    // reset state
    #12;
    check("reset stall_req", {31'd0, stall_req}, 32'd0);
    check("reset busy",      {31'd0, busy},      32'd0);
    check("reset done",      {31'd0, done},      32'd0);
    check("reset result",    result,             32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; chk_en = 1'b1;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d op%0d", i, vecs[i].f), vecs[i].f, vecs[i].x,
             vecs[i].y, vecs[i].has_lit, vecs[i].lit);
    end

    // flush mid-division: no done, result untouched, then a clean restart
    launch(3'd5, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    flush   = 1'b1;
    t_abort = cyc;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush stall_req", {31'd0, stall_req}, 32'd0);
    check("flush result",    result,             old_val);
    run_op("after flush", 3'd7, 32'd1000, 32'd33, 1'b1, 32'd10);

    // asynchronous reset in the middle of a multiply
    launch(3'd0, 32'd7, 32'd6);
    repeat (4) @(posedge clk);
    #3;
    chk_en = 1'b0;
    act    = 1'b0;
    rst    = 1'b0;
    #1;
    check("async rst stall_req", {31'd0, stall_req}, 32'd0);
    check("async rst busy",      {31'd0, busy},      32'd0);
    check("async rst done",      {31'd0, done},      32'd0);
    check("async rst result",    result,             32'd0);
    old_val = 32'd0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; chk_en = 1'b1;
    run_op("divu after reset", 3'd5, 32'd9, 32'd3, 1'b1, 32'd3);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
